// File: rtl/inst_fetch_pkg.sv
// Shared widths, defaults and state codes for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int unsigned AddrLen     = 32;
    localparam int unsigned InstLen     = 32;
    localparam int unsigned ByteLen     = 8;
    localparam int unsigned ICacheLines = 64;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } if_state_e;

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache, one word per line; combinational read, synchronous write.
module inst_fetch_icache
    import inst_fetch_pkg::*;
#(
    parameter int unsigned LINES   = ICacheLines,
    parameter int unsigned IDX_LEN = $clog2(LINES),
    parameter int unsigned TAG_LEN = AddrLen - IDX_LEN - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_LEN-1:0] ridx_i,
    input  logic [TAG_LEN-1:0] rtag_i,
    output logic               hit_c,
    output logic [InstLen-1:0] rdata_c,
    input  logic               we_i,
    input  logic [IDX_LEN-1:0] widx_i,
    input  logic [TAG_LEN-1:0] wtag_i,
    input  logic [InstLen-1:0] wdata_i
);

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   valid_d;
    logic [TAG_LEN-1:0] tag_q  [LINES];
    logic [InstLen-1:0] data_q [LINES];

    // Set the valid bit of the line being filled
    always_comb begin
        valid_d = valid_q;
        if (we_i) begin
            valid_d[widx_i] = 1'b1;
        end
    end

    // Valid bits clear asynchronously so a reset invalidates every line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data storage, no reset needed behind the valid bits
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign hit_c   = valid_q[ridx_i] && (tag_q[ridx_i] == rtag_i);
    assign rdata_c = data_q[ridx_i];

endmodule

// File: rtl/inst_fetch.sv
// IF stage: owns the PC, fetches instructions through the icache or byte-wide memory.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [AddrLen-1:0] RESET_PC     = '0,
    parameter int unsigned        ICACHE_LINES = ICacheLines
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               jump_i,
    input  logic [AddrLen-1:0] jump_addr_i,
    input  logic               mem_grant_i,
    input  logic [ByteLen-1:0] mem_din_i,
    output logic               mem_rd_o,
    output logic [AddrLen-1:0] mem_addr_o,
    output logic [AddrLen-1:0] pc_o,
    output logic [InstLen-1:0] inst_o,
    output logic               inst_valid_o
);

    localparam int unsigned IdxLen   = $clog2(ICACHE_LINES);
    localparam int unsigned TagLen   = AddrLen - IdxLen - 2;
    localparam int unsigned IssueLen = 3;
    localparam int unsigned RecvLen  = 2;

    if_state_e             state_q, state_d;
    logic [AddrLen-1:0]    pc_q, pc_d;
    logic [IssueLen-1:0]   issue_cnt_q, issue_cnt_d;
    logic [RecvLen-1:0]    recv_cnt_q, recv_cnt_d;
    logic [InstLen-1:0]    byte_buf_q, byte_buf_d;
    logic                  inflight_q, inflight_d;
    logic [AddrLen-1:0]    pc_out_q, pc_out_d;
    logic [InstLen-1:0]    inst_q, inst_d;
    logic                  valid_q, valid_d;

    logic                  hit_c;
    logic [InstLen-1:0]    line_c;
    logic                  cache_we_c;
    logic [IdxLen-1:0]     idx_c;
    logic [TagLen-1:0]     tag_c;

    assign idx_c = pc_q[IdxLen+1:2];
    assign tag_c = pc_q[AddrLen-1:IdxLen+2];

    inst_fetch_icache #(
        .LINES   (ICACHE_LINES),
        .IDX_LEN (IdxLen),
        .TAG_LEN (TagLen)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .ridx_i  (idx_c),
        .rtag_i  (tag_c),
        .hit_c   (hit_c),
        .rdata_c (line_c),
        .we_i    (cache_we_c),
        .widx_i  (idx_c),
        .wtag_i  (tag_c),
        .wdata_i (byte_buf_d)
    );

    // Byte requests on a miss; forced quiet while reset is asserted
    assign mem_rd_o   = !rst && (state_q == S_REQ) && !hit_c && !issue_cnt_q[IssueLen-1];
    assign mem_addr_o = rst ? '0 : pc_q + AddrLen'(issue_cnt_q);

    // Next-state: redirect first, then hit/miss handling in S_REQ, consume in S_HOLD
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        byte_buf_d  = byte_buf_q;
        pc_out_d    = pc_out_q;
        inst_d      = inst_q;
        valid_d     = valid_q;
        cache_we_c  = 1'b0;
        inflight_d  = mem_rd_o && mem_grant_i && !jump_i;

        if (jump_i) begin
            pc_d        = jump_addr_i;
            valid_d     = 1'b0;
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            state_d     = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (hit_c) begin
                        inst_d   = line_c;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end else begin
                        if (mem_rd_o && mem_grant_i) begin
                            issue_cnt_d = issue_cnt_q + IssueLen'(1);
                        end
                        if (inflight_q) begin
                            byte_buf_d[{recv_cnt_q, 3'b000} +: ByteLen] = mem_din_i;
                            recv_cnt_d = recv_cnt_q + RecvLen'(1);
                            // Last byte of the word completes the fill
                            if (recv_cnt_q == RecvLen'(3)) begin
                                cache_we_c = 1'b1;
                                inst_d     = byte_buf_d;
                                pc_out_d   = pc_q;
                                valid_d    = 1'b1;
                                state_d    = S_HOLD;
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (valid_q && !stall_i) begin
                        pc_d        = pc_q + AddrLen'(4);
                        valid_d     = 1'b0;
                        issue_cnt_d = '0;
                        recv_cnt_d  = '0;
                        state_d     = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Stage registers, including the registered decode-facing outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            byte_buf_q  <= '0;
            inflight_q  <= 1'b0;
            pc_out_q    <= '0;
            inst_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            byte_buf_q  <= byte_buf_d;
            inflight_q  <= inflight_d;
            pc_out_q    <= pc_out_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
        end
    end

    assign pc_o         = pc_out_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus an architectural fetch model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        mem_grant_i;
    logic [7:0]  mem_din_i;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .mem_grant_i  (mem_grant_i),
        .mem_din_i    (mem_din_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed instruction at 0, an address-derived pattern elsewhere
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ {a[11:8], 4'h0};
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] p);
        return {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Memory port: a granted request returns its byte one cycle later
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    always @(negedge clk) begin
        pend  = mem_rd_o && mem_grant_i;
        paddr = mem_addr_o;
    end
    always @(posedge clk) begin
        #1;
        mem_din_i = pend ? mem_byte(paddr) : 8'hEE;
    end

    // Architectural model: expected PC stream and which PCs the cache must hold
    logic        mval [64];
    logic [31:0] mpc  [64];
    logic [31:0] exp_pc;

    function automatic logic cached(input logic [31:0] p);
        return mval[p[7:2]] && (mpc[p[7:2]] == p);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("m_rst_valid", 32'(inst_valid_o), 32'd0);
            chk("m_rst_rd", 32'(mem_rd_o), 32'd0);
            for (int i = 0; i < 64; i++) mval[i] = 1'b0;
            exp_pc = 32'd0;
        end else begin
            if (inst_valid_o) begin
                chk("m_pc", pc_o, exp_pc);
                chk("m_inst", inst_o, mem_word(exp_pc));
                mval[exp_pc[7:2]] = 1'b1;
                mpc[exp_pc[7:2]]  = exp_pc;
            end else if (cached(exp_pc)) begin
                chk("m_hit_no_rd", 32'(mem_rd_o), 32'd0);
            end
            if (mem_rd_o) begin
                chk("m_rd_miss", 32'(cached(exp_pc)), 32'd0);
                chk("m_rd_addr_in_word", 32'((mem_addr_o - exp_pc) < 32'd4), 32'd1);
            end
            if (jump_i) begin
                exp_pc = jump_addr_i;
            end else if (inst_valid_o && !stall_i) begin
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int unsigned maxc);
        int unsigned n = 0;
        neg();
        while (!inst_valid_o && n < maxc) begin
            nxt();
            neg();
            n++;
        end
        chk("wait_valid", 32'(inst_valid_o), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] a);
        nxt();
        jump_i      = 1'b1;
        jump_addr_i = a;
        nxt();
        jump_i      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
        mem_grant_i = 1'b1; mem_din_i = 8'h00;
        #1;
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        repeat (2) nxt();

        // 1: cold miss at 0 with full grant
        stall_i = 1'b1;
        rst     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("t1_addr", mem_addr_o, 32'(k));
            chk("t1_rd", 32'(mem_rd_o), 32'd1);
            nxt();
        end
        neg(); chk("t1_t4_valid", 32'(inst_valid_o), 32'd0);
        nxt(); neg();
        chk("t1_t5_valid", 32'(inst_valid_o), 32'd1);
        chk("t1_inst", inst_o, 32'h00100513);
        chk("t1_pc", pc_o, 32'd0);

        // 2: redirect to 0 hits
        redirect(32'd0);
        neg();
        chk("t2_valid0", 32'(inst_valid_o), 32'd0);
        chk("t2_rd0", 32'(mem_rd_o), 32'd0);
        nxt(); neg();
        chk("t2_valid1", 32'(inst_valid_o), 32'd1);
        chk("t2_rd", 32'(mem_rd_o), 32'd0);
        chk("t2_inst", inst_o, 32'h00100513);

        // 3: miss at 0x100 with grant denied for 3 cycles on byte 0x102
        redirect(32'h100);
        neg(); chk("t3_a0", mem_addr_o, 32'h100);
        nxt(); neg(); chk("t3_a1", mem_addr_o, 32'h101);
        nxt(); mem_grant_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            neg(); chk("t3_held", mem_addr_o, 32'h102);
            nxt();
        end
        mem_grant_i = 1'b1;
        neg(); chk("t3_regrant", mem_addr_o, 32'h102);
        nxt(); neg(); chk("t3_a3", mem_addr_o, 32'h103);
        nxt(); neg(); chk("t3_t7_valid", 32'(inst_valid_o), 32'd0);
        nxt(); neg();
        chk("t3_t8_valid", 32'(inst_valid_o), 32'd1);
        chk("t3_inst", inst_o, 32'h13121110);
        chk("t3_pc", pc_o, 32'h100);

        // 4: abandon the miss at 4 after two bytes, redirect to 0x200
        redirect(32'h4);
        neg(); chk("t4_a0", mem_addr_o, 32'h4);
        nxt(); neg(); chk("t4_a1", mem_addr_o, 32'h5);
        nxt();
        jump_i = 1'b1; jump_addr_i = 32'h200;
        neg();
        nxt();
        jump_i = 1'b0;
        neg(); chk("t4_new_addr", mem_addr_o, 32'h200);
        wait_valid(20);
        chk("t4_inst", inst_o, 32'h23222120);
        chk("t4_pc", pc_o, 32'h200);
        redirect(32'h4);
        neg(); chk("t4_line1_miss", 32'(mem_rd_o), 32'd1);
        wait_valid(20);
        chk("t4_inst4", inst_o, 32'h07060504);
        redirect(32'h200);
        neg(); chk("t4_200_hit", 32'(mem_rd_o), 32'd0);
        nxt(); neg(); chk("t4_200_valid", 32'(inst_valid_o), 32'd1);

        // 5: stall holds outputs, release advances to pc+4
        for (int k = 0; k < 5; k++) begin
            nxt(); neg();
            chk("t5_hold_pc", pc_o, 32'h200);
            chk("t5_hold_inst", inst_o, 32'h23222120);
        end
        nxt(); stall_i = 1'b0;
        nxt(); stall_i = 1'b1;
        neg();
        chk("t5_next_addr", mem_addr_o, 32'h204);
        chk("t5_next_valid", 32'(inst_valid_o), 32'd0);
        wait_valid(20);
        chk("t5_inst", inst_o, 32'h27262524);
        nxt();
        stall_i = 1'b0; jump_i = 1'b1; jump_addr_i = 32'h300;
        nxt();
        stall_i = 1'b1; jump_i = 1'b0;
        neg(); chk("t5_jc_addr", mem_addr_o, 32'h300);
        wait_valid(20);
        chk("t5_jc_pc", pc_o, 32'h300);

        // 6: cache 0, then reset in the middle of another miss
        redirect(32'd0);
        wait_valid(20);
        redirect(32'h308);
        nxt();
        #3;
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(inst_valid_o), 32'd0);
        chk("t6_pc", pc_o, 32'd0);
        chk("t6_inst", inst_o, 32'd0);
        chk("t6_rd", 32'(mem_rd_o), 32'd0);
        chk("t6_addr", mem_addr_o, 32'd0);
        nxt(); nxt();
        rst = 1'b0;
        neg();
        chk("t6_first_rd", 32'(mem_rd_o), 32'd1);
        chk("t6_first_addr", mem_addr_o, 32'd0);
        wait_valid(20);
        chk("t6_inst_after", inst_o, 32'h00100513);

        // 7: pc+4 wraps from the top of the address space
        redirect(32'hFFFFFFFC);
        wait_valid(20);
        chk("t7_pc", pc_o, 32'hFFFFFFFC);
        chk("t7_inst", inst_o, 32'h0F0E0D0C);
        nxt(); stall_i = 1'b0;
        nxt(); stall_i = 1'b1;
        neg();
        chk("t7_wrap_rd", 32'(mem_rd_o), 32'd0);
        nxt(); neg();
        chk("t7_wrap_pc", pc_o, 32'd0);
        chk("t7_wrap_inst", inst_o, 32'h00100513);

        repeat (3) nxt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
